ram_copy_engine: RTL and testbench

RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

---
 rtl/ram_copy_engine.sv | 139 +++++++++++++
 tb/tb_ram_copy_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: fill/copy engine driving a single-port RAM512 (write on clk edge, async read).
// Define RAM_COPY_CHECKSUM_EN to add the running checksum output of written words.
//
// state | meaning
// IDLE  | waiting for start; RAM port held quiet
// READ  | copy only: fetch word src+i into the data register
// WRITE | store word at dst+i, advance index
// DONE  | one-cycle completion pulse
module ram_copy_engine #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
`ifdef RAM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  state_t              state;
  logic                mode_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W:0]     len_q;
  logic [DATA_W-1:0]   fill_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W:0]     i;
  logic [ADDR_W:0]     i_next;
  logic [DATA_W-1:0]   wr_data;

  always_comb begin
    wr_data = mode_q ? data_q : fill_q;
    i_next  = i + (ADDR_W+1)'(1);
  end

  // RAM port is a decode of state; reset gates the write strobe immediately
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    case (state)
      READ: ram_address = src_q + i[ADDR_W-1:0];
      WRITE: begin
        ram_address = dst_q + i[ADDR_W-1:0];
        ram_in      = wr_data;
        ram_load    = !reset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
      data_q <= '0;
      i      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q <= mode;
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= (len > DEPTH) ? DEPTH : len;
            fill_q <= fill_val;
            i      <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= mode ? READ : WRITE;
            end
          end
        end
        READ: begin
          data_q <= ram_out;
          state  <= WRITE;
        end
        WRITE: begin
          i <= i_next;
          if (i_next == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= mode_q ? READ : WRITE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset)
      csum_q <= '0;
    else if (state == IDLE && start)
      csum_q <= '0;
    else if (state == WRITE)
      csum_q <= csum_q + wr_data;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: directed scenarios with a RAM model and a write scoreboard.
// Compile with RAM_COPY_CHECKSUM_EN to also check the checksum output.
module tb_ram_copy_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [8:0]  src;
  logic [8:0]  dst;
  logic [9:0]  len;
  logic [15:0] fill_val;
  logic        busy;
  logic        done;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [8:0]  ram_address;
  logic [15:0] ram_out;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  ram_copy_engine dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .src(src),
    .dst(dst),
    .len(len),
    .fill_val(fill_val),
    .busy(busy),
    .done(done),
    .ram_in(ram_in),
    .ram_load(ram_load),
    .ram_address(ram_address),
    .ram_out(ram_out)
`ifdef RAM_COPY_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM512 model plus a bench-side preload port
  logic [15:0] mem [512];
  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (ram_load)
      mem[ram_address] <= ram_in;
    else if (pre_we)
      mem[pre_addr] <= pre_data;
  end
  assign ram_out = mem[ram_address];

  logic [15:0] ref_m [512];
  logic [24:0] exp_q [$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e[24:16]));
        chk("wr_data", 32'(ram_in), 32'(e[15:0]));
      end
    end
  end

  task automatic pre(input logic [8:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_m[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic op(input logic m, input logic [8:0] s, input logic [8:0] d,
                    input logic [9:0] l, input logic [15:0] fv, input bit inject,
                    input string tag);
    int n, cyc, dn, dpos;
    logic [8:0]  a;
    logic [15:0] w, sum;
    n   = (l > 10'd512) ? 512 : int'(l);
    sum = '0;
    for (int j = 0; j < n; j++) begin
      a = d + 9'(j);
      w = m ? ref_m[s + 9'(j)] : fv;
      ref_m[a] = w;
      exp_q.push_back({a, w});
      sum = sum + w;
    end
    @(posedge clk); #1;
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = fv;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; dn = 0; dpos = 0;
    while (cyc < 1100) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (done) begin dn++; dpos = cyc; end
      if (inject && cyc == 3) begin
        start = 1'b1; mode = 1'b0; src = 9'd50; dst = 9'd400; len = 10'd2;
      end
      if (inject && cyc == 4) start = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 32'(cyc), m ? 32'(2*n+1) : 32'(n+1));
    chk({tag, "_done_count"}, 32'(dn), 32'd1);
    chk({tag, "_done_last"}, 32'(dpos), 32'(cyc));
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
`ifdef RAM_COPY_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(checksum), 32'(sum));
`endif
  endtask

  initial begin
    int nb, nd;
    reset = 1'b1; start = 1'b1; mode = 1'b0; src = '0; dst = 9'd5; len = 10'd5;
    fill_val = 16'h0001; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load", 32'(ram_load), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_in", 32'(ram_in), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_with_reset_ignored", 32'(busy), 32'd0);

    op(1'b0, 9'd0, 9'd8, 10'd3, 16'h2008, 1'b0, "fill");
    chk("fill_m8", 32'(mem[8]), 32'h2008);
    chk("fill_m10", 32'(mem[10]), 32'h2008);
`ifdef RAM_COPY_CHECKSUM_EN
    chk("fill_checksum_6018", 32'(checksum), 32'h6018);
`endif

    pre(9'd25, 16'h4025);
    pre(9'd26, 16'h5037);
    op(1'b1, 9'd25, 9'd363, 10'd2, 16'h0, 1'b0, "copy");
    chk("copy_m363", 32'(mem[363]), 32'h4025);
    chk("copy_m364", 32'(mem[364]), 32'h5037);

    pre(9'd1, 16'h1234);
    op(1'b0, 9'd0, 9'd511, 10'd2, 16'h7511, 1'b0, "wrap");
    chk("wrap_m511", 32'(mem[511]), 32'h7511);
    chk("wrap_m0", 32'(mem[0]), 32'h7511);
    chk("wrap_m1_kept", 32'(mem[1]), 32'h1234);

    op(1'b0, 9'd7, 9'd7, 10'd0, 16'hdead, 1'b0, "len0");

    for (int j = 0; j < 5; j++) pre(9'(j), 16'h1000 + 16'(j));
    op(1'b1, 9'd0, 9'd1, 10'd4, 16'h0, 1'b0, "overlap");
    chk("overlap_m4", 32'(mem[4]), 32'h1000);

    op(1'b0, 9'd0, 9'd0, 10'd700, 16'h5a5a, 1'b0, "len_clamp");
    chk("clamp_m511", 32'(mem[511]), 32'h5a5a);

    for (int j = 0; j < 4; j++) pre(9'd10 + 9'(j), 16'h0b00 + 16'(j));
    op(1'b1, 9'd10, 9'd300, 10'd4, 16'h0, 1'b1, "busy_start");
    nb = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("busy_start_not_queued", 32'(nb), 32'd0);
    chk("busy_start_m303", 32'(mem[303]), 32'h0b03);

    ref_m[100] = 16'habcd;
    ref_m[101] = 16'habcd;
    exp_q.push_back({9'd100, 16'habcd});
    exp_q.push_back({9'd101, 16'habcd});
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; dst = 9'd100; len = 10'd10; fill_val = 16'habcd;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_load_gated", 32'(ram_load), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    nb = 0; nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
    chk("abort_no_busy", 32'(nb), 32'd0);
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_writes_left", 32'(exp_q.size()), 32'd0);
    chk("abort_m101", 32'(mem[101]), 32'habcd);
    chk("abort_m102_kept", 32'(mem[102]), 32'(ref_m[102]));
`ifdef RAM_COPY_CHECKSUM_EN
    chk("abort_checksum", 32'(checksum), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
